// File: rtl/noc_packet_sink_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared types and helpers for the NoC ejection-side packet sink.
//   - flit_type_e : 2-bit flit type carried in the top bits of every flit
//   - vc_state_e  : per-VC reassembly state
//   - pkt_desc_t  : descriptor pushed per completed packet. Fields are sized
//                   for the largest supported configuration (VC <= 16,
//                   DIM <= 16). Narrower builds zero-extend into them.
//   - get_dest/get_src/get_msg : field extraction from a zero-extended flit
//   - sat_inc     : saturating 16-bit increment for the length counter
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int MAX_VC_W = 4;
    localparam int MAX_R    = 4;
    localparam int MSG_W    = 12;
    localparam int LEN_W    = 16;
    localparam int ERR_W    = 4;

    // Bit positions inside pkt_err / pkt_desc_t.err
    localparam int ERR_TRUNC = 0;
    localparam int ERR_DEST  = 1;
    localparam int ERR_LEN   = 2;
    localparam int ERR_TAIL  = 3;

    typedef enum logic [1:0] {
        BODY0 = 2'b00,
        HEAD  = 2'b01,
        BODY1 = 2'b10,
        TAIL  = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } vc_state_e;

    typedef struct packed {
        logic [MAX_VC_W-1:0] vc;
        logic [2*MAX_R-1:0]  src;
        logic [MSG_W-1:0]    msg;
        logic [LEN_W-1:0]    len;
        logic [ERR_W-1:0]    err;
    } pkt_desc_t;

    // {destY, destX} occupies the lowest 2R bits.
    function automatic logic [2*MAX_R-1:0] get_dest(input logic [63:0] flit, input int r);
        return (2*MAX_R)'(flit & ((64'd1 << (2*r)) - 64'd1));
    endfunction

    // Source is stored Y-below-X in the flit but reported as {Y, X}.
    function automatic logic [2*MAX_R-1:0] get_src(input logic [63:0] flit, input int r);
        logic [63:0] mask;
        mask = (64'd1 << r) - 64'd1;
        return (2*MAX_R)'(((((flit >> (2*r)) & mask)) << r) | ((flit >> (3*r)) & mask));
    endfunction

    function automatic logic [MSG_W-1:0] get_msg(input logic [63:0] flit, input int r);
        return MSG_W'((flit >> (4*r)) & 64'hFFF);
    endfunction

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] x);
        return (x == '1) ? x : x + LEN_W'(1);
    endfunction

endpackage

// File: rtl/noc_packet_sink_if.sv
// ---------------------------------------------------------------------------
// noc_packet_sink_if
//   Flit ingress (valid/ready, VC tagged) and descriptor egress (valid/ready)
//   of the packet sink, plus its status counters.
//   slave  : view of the sink itself
//   master : view of the router / consumer environment
//   err_count exists only when NOC_SINK_ERR_COUNT_EN is defined.
// ---------------------------------------------------------------------------
interface noc_packet_sink_if import noc_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int VC_W       = 2,
    parameter int R          = 1
);
    logic [DATA_WIDTH-1:0] flit_data;
    logic                  flit_valid;
    logic [VC_W-1:0]       flit_vc;
    logic                  flit_ready;

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [VC_W-1:0]       pkt_vc;
    logic [2*R-1:0]        pkt_src;
    logic [MSG_W-1:0]      pkt_msg;
    logic [LEN_W-1:0]      pkt_len;
    logic [ERR_W-1:0]      pkt_err;
    logic [31:0]           pkts_received;
`ifdef NOC_SINK_ERR_COUNT_EN
    logic [15:0]           err_count;
`endif

    modport slave (
        input  flit_data, flit_valid, flit_vc, pkt_ready,
        output flit_ready, pkt_valid, pkt_vc, pkt_src, pkt_msg, pkt_len, pkt_err,
        output pkts_received
`ifdef NOC_SINK_ERR_COUNT_EN
        , output err_count
`endif
    );

    modport master (
        output flit_data, flit_valid, flit_vc, pkt_ready,
        input  flit_ready, pkt_valid, pkt_vc, pkt_src, pkt_msg, pkt_len, pkt_err,
        input  pkts_received
`ifdef NOC_SINK_ERR_COUNT_EN
        , input err_count
`endif
    );

endinterface

// File: rtl/noc_packet_sink_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy flags.
//   Ports: clk, rst (sync, active-high), push/wr_data, pop/rd_data,
//          full, empty. DEPTH must be a power of two (>= 2).
//   rd_data shows the head entry; it is only meaningful while !empty.
//   Push while full and pop while empty are ignored.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/noc_packet_sink.sv
// ---------------------------------------------------------------------------
// noc_packet_sink
//   Ejection-side network interface. Accepts one flit per cycle from a router
//   local port, reassembles packets independently per VC, checks framing,
//   destination, length and head/tail consistency, and queues one descriptor
//   per completed (or truncated) packet.
//   Ports: clk, rst (sync, active-high), bus (noc_packet_sink_if.slave):
//     flit_data/flit_valid/flit_vc/flit_ready  flit ingress
//     pkt_valid/pkt_ready/pkt_vc/src/msg/len/err descriptor egress
//     pkts_received                             descriptors pushed (wraps)
//     err_count                                 only with NOC_SINK_ERR_COUNT_EN:
//                                               errored descriptors + orphan
//                                               flits, saturating
//   Supported range: VC <= 16, DIM <= 16.
// ---------------------------------------------------------------------------
module noc_packet_sink import noc_pkg::*; #(
    parameter int DATA_WIDTH       = 32,
    parameter int VC               = 4,
    parameter int DIM              = 2,
    parameter int NODE_ID          = 0,
    parameter int FLITS_PER_PACKET = 16,
    parameter int DESC_DEPTH       = 4
) (
    input logic              clk,
    input logic              rst,
    noc_packet_sink_if.slave bus
);
    localparam int VC_W = (VC > 1) ? $clog2(VC) : 1;
    localparam int R    = (DIM > 1) ? $clog2(DIM) : 1;

    flit_type_e       ftype;
    logic [VC_W-1:0]  v;
    logic [2*R-1:0]   f_dest, f_src;
    logic [MSG_W-1:0] f_msg;
    logic             xfer;

    vc_state_e        state_q   [VC], state_d   [VC];
    logic [LEN_W-1:0] len_q     [VC], len_d     [VC];
    logic [2*R-1:0]   src_q     [VC], src_d     [VC];
    logic [MSG_W-1:0] msg_q     [VC], msg_d     [VC];
    logic             dest_ok_q [VC], dest_ok_d [VC];

    logic             push, pop, start_pkt, fifo_full, fifo_empty;
    logic [LEN_W-1:0] len_inc;
    pkt_desc_t        desc_in, desc_out;
    logic [31:0]      pkts_received_q;
`ifdef NOC_SINK_ERR_COUNT_EN
    logic             orphan;
    logic [15:0]      err_count_q;
`endif

    assign v      = bus.flit_vc;
    assign ftype  = flit_type_e'(bus.flit_data[DATA_WIDTH-1 -: 2]);
    assign f_dest = (2*R)'(get_dest(64'(bus.flit_data), R));
    assign f_src  = (2*R)'(get_src(64'(bus.flit_data), R));
    assign f_msg  = get_msg(64'(bus.flit_data), R);

    // Ready depends only on registered occupancy, so a same-cycle pop cannot
    // reopen a full sink and no comb path runs from pkt_ready to flit_ready.
    assign bus.flit_ready = !fifo_full;
    assign xfer           = bus.flit_valid && !fifo_full;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        src_d     = src_q;
        msg_d     = msg_q;
        dest_ok_d = dest_ok_q;
        push      = 1'b0;
        start_pkt = 1'b0;
`ifdef NOC_SINK_ERR_COUNT_EN
        orphan    = 1'b0;
`endif
        len_inc      = sat_inc(len_q[v]);
        desc_in      = '0;
        desc_in.vc   = MAX_VC_W'(v);
        desc_in.src  = (2*MAX_R)'(src_q[v]);
        desc_in.msg  = msg_q[v];
        desc_in.len  = len_inc;

        if (xfer) begin
            unique case (state_q[v])
                IDLE: begin
                    if (ftype == HEAD) start_pkt = 1'b1;
`ifdef NOC_SINK_ERR_COUNT_EN
                    else               orphan    = 1'b1;
`endif
                end
                RECV: begin
                    case (ftype)
                        HEAD: begin
                            // Close the old packet as truncated, then reuse
                            // this head to open the next one.
                            push                 = 1'b1;
                            desc_in.len          = len_q[v];
                            desc_in.err[ERR_TRUNC] = 1'b1;
                            start_pkt            = 1'b1;
                        end
                        TAIL: begin
                            push                   = 1'b1;
                            desc_in.err[ERR_DEST]  = !dest_ok_q[v];
                            desc_in.err[ERR_LEN]   = (len_inc != LEN_W'(FLITS_PER_PACKET));
                            desc_in.err[ERR_TAIL]  = (f_src != src_q[v]) || (f_msg != msg_q[v]);
                            state_d[v]             = IDLE;
                        end
                        default: len_d[v] = len_inc;
                    endcase
                end
                default: state_d[v] = IDLE;
            endcase
        end

        if (start_pkt) begin
            state_d[v]   = RECV;
            len_d[v]     = LEN_W'(1);
            src_d[v]     = f_src;
            msg_d[v]     = f_msg;
            dest_ok_d[v] = (f_dest == (2*R)'(NODE_ID));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VC; i++) begin
                state_q[i]   <= IDLE;
                len_q[i]     <= '0;
                src_q[i]     <= '0;
                msg_q[i]     <= '0;
                dest_ok_q[i] <= 1'b0;
            end
            pkts_received_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            src_q     <= src_d;
            msg_q     <= msg_d;
            dest_ok_q <= dest_ok_d;
            if (push) pkts_received_q <= pkts_received_q + 32'd1;
        end
    end

`ifdef NOC_SINK_ERR_COUNT_EN
    // A flit is either a push or an orphan, never both, so +1 per cycle suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (((push && desc_in.err != '0) || orphan) && err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end
    assign bus.err_count = err_count_q;
`endif

    sync_fifo #(
        .WIDTH($bits(pkt_desc_t)),
        .DEPTH(DESC_DEPTH)
    ) u_desc_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_data(desc_in),
        .pop    (pop),
        .rd_data(desc_out),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign pop = bus.pkt_ready && !fifo_empty;

    // Fields are forced to zero while empty so unwritten storage never leaks out.
    assign bus.pkt_valid     = !fifo_empty;
    assign bus.pkt_vc        = fifo_empty ? '0 : VC_W'(desc_out.vc);
    assign bus.pkt_src       = fifo_empty ? '0 : (2*R)'(desc_out.src);
    assign bus.pkt_msg       = fifo_empty ? '0 : desc_out.msg;
    assign bus.pkt_len       = fifo_empty ? '0 : desc_out.len;
    assign bus.pkt_err       = fifo_empty ? '0 : desc_out.err;
    assign bus.pkts_received = pkts_received_q;

endmodule
